// File: rtl/microcode_sequencer_stk.sv
// Microcode sequencer: computes the registered control-ROM address each cycle from
// the sequencing fields, flags and requests, with a LIFO micro-subroutine stack.
module microcode_sequencer_stk #(
    parameter int UADDR_W     = 14,
    parameter int OFFSET_W    = 7,
    parameter int IR_W        = 8,
    parameter int DATA_W      = 8,
    parameter int EXT_COND    = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    parameter int FETCH_ADDR  = 'h10,
    parameter int TRAP_ADDR   = 'h20,
    localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [2:0]             ctrl_typ,
    input  logic [OFFSET_W-1:0]    ctrl_offset,
    input  logic [3:0]             ctrl_cond_sel,
    input  logic                   ctrl_cond_invert,
    input  logic                   ctrl_cond_flag_src,
    input  logic [1:0]             ctrl_u_zf_in_src,
    input  logic [1:0]             ctrl_u_cf_in_src,
    input  logic                   ctrl_u_sf_in_src,
    input  logic                   ctrl_u_of_in_src,
    input  logic [IR_W-1:0]        ir,
    input  logic [3:0]             alu_flags,
    input  logic                   alu_final_cf,
    input  logic                   alu_of,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic [DATA_W-1:0]      z_bus,
    input  logic [EXT_COND-1:0]    ext_cond,
    input  logic                   dma_req,
    input  logic                   int_pending,
    input  logic                   stall,
    input  logic                   err_clr,
    output logic [UADDR_W-1:0]     u_address,
    output logic [3:0]             u_flags,
    output logic [LVL_W-1:0]       ustack_level,
    output logic                   ustack_ovf,
    output logic                   ustack_unf
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        T_JMP    = 3'd0,
        T_BR     = 3'd1,
        T_FETCH  = 3'd2,
        T_DECODE = 3'd3,
        T_CALL   = 3'd4,
        T_RET    = 3'd5,
        T_NEXT   = 3'd6,
        T_CCALL  = 3'd7
    } seq_typ_e;

    // Flag vectors are {of,sf,cf,zf}.
    function automatic logic sel_cond(input logic [3:0]          sel,
                                      input logic [3:0]          f,
                                      input logic                dma,
                                      input logic [EXT_COND-1:0] ext);
        logic r;
        r = 1'b0;
        case (sel)
            4'd0: r = f[0];
            4'd1: r = f[1];
            4'd2: r = f[2];
            4'd3: r = f[3];
            4'd4: r = f[2] ^ f[3];
            4'd5: r = (f[2] ^ f[3]) | f[0];
            4'd6: r = f[1] | f[0];
            4'd7: r = dma;
            default: begin
                for (int i = 0; i < EXT_COND; i++) begin
                    if (int'(sel) == i + 8) r = ext[i];
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [3:0] next_flags(input logic [3:0]        uf,
                                              input logic [1:0]        zf_src,
                                              input logic [1:0]        cf_src,
                                              input logic              sf_src,
                                              input logic              of_src,
                                              input logic [3:0]        af,
                                              input logic              fcf,
                                              input logic              aof,
                                              input logic [DATA_W-1:0] aout,
                                              input logic [DATA_W-1:0] zb);
        logic [3:0] r;
        r = uf;
        case (zf_src)
            2'd1:    r[0] = af[0];
            2'd2:    r[0] = af[0] & uf[0];
            default: r[0] = uf[0];
        endcase
        case (cf_src)
            2'd1:    r[1] = fcf;
            2'd2:    r[1] = aout[0];
            2'd3:    r[1] = aout[DATA_W-1];
            default: r[1] = uf[1];
        endcase
        if (sf_src) r[2] = zb[DATA_W-1];
        if (of_src) r[3] = aof;
        return r;
    endfunction

    logic [UADDR_W-1:0]        stack_mem [STACK_DEPTH];
    logic signed [UADDR_W-1:0] off_sext;
    logic [UADDR_W-1:0]        addr_tgt;
    logic [UADDR_W-1:0]        addr_inc;
    logic [UADDR_W-1:0]        addr_nxt;
    logic [3:0]                flag_mux;
    logic [3:0]                flags_nxt;
    logic                      cond;
    logic                      stk_full;
    logic                      stk_empty;
    logic                      do_push;
    logic                      do_pop;
    logic                      set_ovf;
    logic                      set_unf;
    logic [PTR_W-1:0]          push_ptr;
    logic [PTR_W-1:0]          pop_ptr;
    logic                      unused_bits;

    assign unused_bits = ^{alu_out, z_bus};

    assign off_sext  = {{(UADDR_W - OFFSET_W){ctrl_offset[OFFSET_W-1]}}, ctrl_offset};
    assign addr_tgt  = u_address + $unsigned(off_sext);
    assign addr_inc  = u_address + UADDR_W'(1);
    assign flag_mux  = ctrl_cond_flag_src ? u_flags : alu_flags;
    assign cond      = sel_cond(ctrl_cond_sel, flag_mux, dma_req, ext_cond) ^ ctrl_cond_invert;
    assign stk_full  = (ustack_level == LVL_W'(STACK_DEPTH));
    assign stk_empty = (ustack_level == '0);
    assign push_ptr  = PTR_W'(ustack_level);
    assign pop_ptr   = PTR_W'(ustack_level - LVL_W'(1));
    assign flags_nxt = next_flags(u_flags, ctrl_u_zf_in_src, ctrl_u_cf_in_src,
                                  ctrl_u_sf_in_src, ctrl_u_of_in_src, alu_flags,
                                  alu_final_cf, alu_of, alu_out, z_bus);

    // Next-address decode; a CALL on a full stack still jumps but drops the push.
    always_comb begin
        addr_nxt = addr_inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (seq_typ_e'(ctrl_typ))
            T_JMP:    addr_nxt = addr_tgt;
            T_BR:     addr_nxt = cond ? addr_tgt : addr_inc;
            T_FETCH:  addr_nxt = (dma_req | int_pending) ? UADDR_W'(TRAP_ADDR)
                                                         : UADDR_W'(FETCH_ADDR);
            T_DECODE: addr_nxt = UADDR_W'(ir);
            T_CALL, T_CCALL: begin
                if (ctrl_typ == T_CALL || cond) begin
                    addr_nxt = addr_tgt;
                    do_push  = ~stk_full;
                    set_ovf  = stk_full;
                end
            end
            T_RET: begin
                if (stk_empty) begin
                    addr_nxt = UADDR_W'(FETCH_ADDR);
                    set_unf  = 1'b1;
                end else begin
                    addr_nxt = stack_mem[pop_ptr];
                    do_pop   = 1'b1;
                end
            end
            default:  addr_nxt = addr_inc;
        endcase
    end

    // Control state: address, flags, level and sticky errors.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            u_address    <= UADDR_W'(RESET_ADDR);
            u_flags      <= '0;
            ustack_level <= '0;
            ustack_ovf   <= 1'b0;
            ustack_unf   <= 1'b0;
        end else if (!stall) begin
            u_address <= addr_nxt;
            u_flags   <= flags_nxt;
            if (do_push)
                ustack_level <= ustack_level + LVL_W'(1);
            else if (do_pop)
                ustack_level <= ustack_level - LVL_W'(1);
            ustack_ovf <= set_ovf | (ustack_ovf & ~err_clr);
            ustack_unf <= set_unf | (ustack_unf & ~err_clr);
        end
    end

    // Stack storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (!stall && do_push)
            stack_mem[push_ptr] <= addr_inc;
    end

endmodule
